obi_master_arbiter: RTL and testbench

OBI_MASTER_ARBITER -- requirements
Module: obi_master_arbiter

---
 rtl/obi_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_obi_master_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_master_arbiter.sv
// Two-master OBI arbiter in front of a single X-HEEP slave port: round-robin
// selection held stable until grant, outstanding limit, and in-order response routing.
module obi_master_arbiter #(
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0 (program loader)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  // master 1 (readback port)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  // shared port towards X-HEEP
  output logic        req,
  output logic        we,
  output logic [3:0]  be,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        gnt,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  // status
  output logic        busy,
  output logic        resp_err
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  logic [CW-1:0]        cnt_q, cnt_d, wr_idx;
  logic                 lock_q, lock_d;
  master_e              lock_sel_q, prio_q, prio_d, sel;
  logic [MAX_OUTST-1:0] id_q, id_d;
  logic                 resp_err_q;
  logic                 sel_req, full, hs, rv_ok;

  // Selection: a locked (requested but not yet granted) master keeps the port.
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    sel = M0;
    if (lock_q)                sel = lock_sel_q;
    else if (m0_req && m1_req) sel = prio_q;
    else if (m1_req)           sel = M1;
  end

  assign sel_req = (sel == M1) ? m1_req : m0_req;
  assign full    = (cnt_q == CW'(MAX_OUTST));
  assign req     = rst_n & sel_req & ~full;
  assign hs      = req & gnt;

  always_comb begin
    we    = 1'b0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    if (req) begin
      if (sel == M1) begin
        we    = m1_we;
        be    = m1_be;
        addr  = m1_addr;
        wdata = m1_wdata;
      end else begin
        we    = m0_we;
        be    = m0_be;
        addr  = m0_addr;
        wdata = m0_wdata;
      end
    end
  end

  assign m0_gnt = hs & (sel == M0);
  assign m1_gnt = hs & (sel == M1);

  // A response with nothing outstanding is dropped; the FIFO head owns the rest.
  assign rv_ok     = rst_n & rvalid & (cnt_q != '0);
  assign m0_rvalid = rv_ok & ~id_q[0];
  assign m1_rvalid = rv_ok &  id_q[0];
  assign m0_rdata  = rst_n ? rdata : '0;
  assign m1_rdata  = rst_n ? rdata : '0;

  assign busy     = req | (cnt_q != '0);
  assign resp_err = resp_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !rv_ok)      cnt_d = cnt_q + CW'(1);
    else if (!hs && rv_ok) cnt_d = cnt_q - CW'(1);

    lock_d = sel_req & ~hs;
    prio_d = hs ? master_e'(~prio_q) : prio_q;

    // Id FIFO as a shift register: head at index 0, occupancy equals cnt_q.
    id_d = id_q;
    if (rv_ok) begin
      for (int i = 0; i < int'(MAX_OUTST) - 1; i++) id_d[i] = id_q[i+1];
    end
    wr_idx = rv_ok ? cnt_q - CW'(1) : cnt_q;
    for (int i = 0; i < int'(MAX_OUTST); i++) begin
      if (hs && wr_idx == CW'(i)) id_d[i] = sel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= M0;
      prio_q     <= M0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= sel;
      prio_q     <= prio_d;
      if (rvalid && cnt_q == '0) resp_err_q <= 1'b1;
    end
  end

  // NOTE: the id storage carries no reset; entries are only read below cnt_q,
  // which is cleared, so stale contents are never observed.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

endmodule

// File: tb/tb_obi_master_arbiter.sv
// Self-checking bench for obi_master_arbiter: directed vector table, reset
// sequences, then random traffic against a queue-based reference model.
module tb_obi_master_arbiter;

  localparam int MAX_OUTST = 2;
  localparam logic [31:0] A0 = 32'hA000_0010;
  localparam logic [31:0] A1 = 32'hB100_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        busy, resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_master_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .busy(busy), .resp_err(resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        m0r, m1r, g, rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_g0, e_g1, e_rv0, e_rv1, e_busy, e_err;
  } vec_t;

  function automatic vec_t row(input logic m0r, m1r, g, rv, e_req, input logic [31:0] e_addr,
                               input logic e_g0, e_g1, e_rv0, e_rv1, e_busy, e_err);
    vec_t v;
    v.m0r = m0r; v.m1r = m1r; v.g = g; v.rv = rv;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1;
    v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[$];

  // reference model state for the random phase
  int   q_ids[$];
  int   m_lock;
  int   m_prio;
  bit   m_err;
  bit   pend[2];
  bit   pwe[2];
  logic [3:0]  pbe[2];
  logic [31:0] paddr[2], pwdata[2];

  task automatic drive_idle();
    m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    gnt = 0; rvalid = 0; rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},      32'(req),      32'd0);
    check({tag, ".m0_gnt"},   32'(m0_gnt),   32'd0);
    check({tag, ".m1_gnt"},   32'(m1_gnt),   32'd0);
    check({tag, ".m1_rvalid"},32'(m1_rvalid),32'd0);
    check({tag, ".addr"},     addr,          32'd0);
    check({tag, ".m1_rdata"}, m1_rdata,      32'd0);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state, with live-looking inputs
    drive_idle();
    rst_n = 0;
    m0_req = 1; m0_addr = A0; m1_req = 1; m1_addr = A1; gnt = 1; rvalid = 1; rdata = 32'h1234_5678;
    #3;
    check_all_zero("reset");
    drive_idle();
    @(negedge clk);
    rst_n = 1;

    // ---------------- directed vector table
    //            m0 m1 g rv | req addr | g0 g1 rv0 rv1 busy err
    vecs.push_back(row(0,0,0,0, 0,0,  0,0,0,0, 0,0)); // idle
    vecs.push_back(row(1,0,1,0, 1,A0, 1,0,0,0, 1,0)); // m0 write alone
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,1,0, 1,0)); // its response
    vecs.push_back(row(0,1,1,0, 1,A1, 0,1,0,0, 1,0)); // m1 alone
    vecs.push_back(row(1,1,1,1, 1,A0, 1,0,0,1, 1,0)); // alternation, rvalid answers older
    vecs.push_back(row(1,1,1,1, 1,A1, 0,1,1,0, 1,0));
    vecs.push_back(row(1,1,1,1, 1,A0, 1,0,0,1, 1,0));
    vecs.push_back(row(1,1,1,1, 1,A1, 0,1,1,0, 1,0));
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,0,1, 1,0));
    vecs.push_back(row(0,1,0,0, 1,A1, 0,0,0,0, 1,0)); // m1 stalled
    vecs.push_back(row(1,1,0,0, 1,A1, 0,0,0,0, 1,0)); // held despite m0 having priority
    vecs.push_back(row(1,1,0,0, 1,A1, 0,0,0,0, 1,0));
    vecs.push_back(row(1,1,1,0, 1,A1, 0,1,0,0, 1,0)); // granted
    vecs.push_back(row(1,0,1,1, 1,A0, 1,0,0,1, 1,0)); // m0 served next
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,1,0, 1,0));
    vecs.push_back(row(1,0,1,0, 1,A0, 1,0,0,0, 1,0)); // fill to MAX_OUTST
    vecs.push_back(row(0,1,1,0, 1,A1, 0,1,0,0, 1,0));
    vecs.push_back(row(1,0,1,0, 0,0,  0,0,0,0, 1,0)); // full: req blocked
    vecs.push_back(row(1,0,1,1, 0,0,  0,0,1,0, 1,0)); // rvalid frees a slot next cycle
    vecs.push_back(row(1,0,1,0, 1,A0, 1,0,0,0, 1,0)); // reasserted
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,0,1, 1,0));
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,1,0, 1,0));
    vecs.push_back(row(0,0,0,1, 0,0,  0,0,0,0, 0,0)); // unexpected response
    vecs.push_back(row(0,0,0,0, 0,0,  0,0,0,0, 0,1)); // sticky error
    vecs.push_back(row(0,1,1,0, 1,A1, 0,1,0,0, 1,1));
    vecs.push_back(row(0,1,0,0, 1,A1, 0,0,0,0, 1,1)); // m1 stalled, one outstanding

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      @(negedge clk);
      m0_req = vecs[i].m0r; m0_we = 1; m0_be = 4'hF; m0_addr = A0; m0_wdata = 32'h0000_1111;
      m1_req = vecs[i].m1r; m1_we = 0; m1_be = 4'h3; m1_addr = A1; m1_wdata = 32'h0000_2222;
      gnt = vecs[i].g; rvalid = vecs[i].rv; rdata = 32'hD000_0000 + 32'(i);
      #1;
      check({t, ".req"},       32'(req),       32'(vecs[i].e_req));
      check({t, ".addr"},      addr,           vecs[i].e_addr);
      check({t, ".m0_gnt"},    32'(m0_gnt),    32'(vecs[i].e_g0));
      check({t, ".m1_gnt"},    32'(m1_gnt),    32'(vecs[i].e_g1));
      check({t, ".m0_rvalid"}, 32'(m0_rvalid), 32'(vecs[i].e_rv0));
      check({t, ".m1_rvalid"}, 32'(m1_rvalid), 32'(vecs[i].e_rv1));
      check({t, ".busy"},      32'(busy),      32'(vecs[i].e_busy));
      check({t, ".resp_err"},  32'(resp_err),  32'(vecs[i].e_err));
      check({t, ".m0_rdata"},  m0_rdata,       32'hD000_0000 + 32'(i));
      check({t, ".m1_rdata"},  m1_rdata,       32'hD000_0000 + 32'(i));
    end

    // ---------------- reset pulse mid-transaction
    @(negedge clk);
    m1_req = 1; gnt = 1; rvalid = 0;
    rst_n = 0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1;
    m1_req = 0; gnt = 0; rvalid = 1;
    #1;
    check("postrst.m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("postrst.m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("postrst.busy",      32'(busy),      32'd0);
    check("postrst.resp_err",  32'(resp_err),  32'd0);
    @(negedge clk);
    rvalid = 0;
    #1;
    check("postrst.resp_err_set", 32'(resp_err), 32'd1);
    check("postrst.busy_idle",    32'(busy),     32'd0);

    // ---------------- random traffic against reference model
    @(negedge clk);
    drive_idle();
    rst_n = 0;
    #1;
    rst_n = 1;
    q_ids.delete();
    m_lock = -1; m_prio = 0; m_err = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pwe[i] = 0; pbe[i] = '0; paddr[i] = '0; pwdata[i] = '0;
    end

    for (int c = 0; c < 600; c++) begin
      int          cand;
      bit          e_req, e_rv0, e_rv1;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      bit          e_we;
      string       t;
      t = $sformatf("rnd%0d", c);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1;
          pwe[i]    = 1'($urandom);
          pbe[i]    = 4'($urandom);
          paddr[i]  = $urandom;
          pwdata[i] = $urandom;
        end
      end
      m0_req = pend[0]; m0_we = pwe[0]; m0_be = pbe[0]; m0_addr = paddr[0]; m0_wdata = pwdata[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_be = pbe[1]; m1_addr = paddr[1]; m1_wdata = pwdata[1];
      gnt    = ($urandom_range(0, 3) != 0);
      rvalid = (q_ids.size() > 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
      rdata  = $urandom;
      #1;

      // who owns the port: a stalled master first, then priority, then the lone requester
      cand = -1;
      if (m_lock >= 0)            cand = m_lock;
      else if (pend[0] && pend[1]) cand = m_prio;
      else if (pend[1])           cand = 1;
      else if (pend[0])           cand = 0;
      e_req   = (cand >= 0) && pend[cand] && (q_ids.size() < MAX_OUTST);
      e_we    = e_req ? pwe[cand]    : 1'b0;
      e_be    = e_req ? pbe[cand]    : 4'h0;
      e_addr  = e_req ? paddr[cand]  : 32'h0;
      e_wdata = e_req ? pwdata[cand] : 32'h0;
      e_rv0   = rvalid && q_ids.size() > 0 && q_ids[0] == 0;
      e_rv1   = rvalid && q_ids.size() > 0 && q_ids[0] == 1;

      check({t, ".req"},       32'(req),       32'(e_req));
      check({t, ".we"},        32'(we),        32'(e_we));
      check({t, ".be"},        32'(be),        32'(e_be));
      check({t, ".addr"},      addr,           e_addr);
      check({t, ".wdata"},     wdata,          e_wdata);
      check({t, ".m0_gnt"},    32'(m0_gnt),    32'(e_req && gnt && cand == 0));
      check({t, ".m1_gnt"},    32'(m1_gnt),    32'(e_req && gnt && cand == 1));
      check({t, ".m0_rvalid"}, 32'(m0_rvalid), 32'(e_rv0));
      check({t, ".m1_rvalid"}, 32'(m1_rvalid), 32'(e_rv1));
      check({t, ".m0_rdata"},  m0_rdata,       rdata);
      check({t, ".busy"},      32'(busy),      32'(e_req || q_ids.size() > 0));
      check({t, ".resp_err"},  32'(resp_err),  32'(m_err));

      // advance the model to the state after this clock edge
      if (rvalid) begin
        if (q_ids.size() > 0) void'(q_ids.pop_front());
        else                  m_err = 1;
      end
      if (e_req && gnt) begin
        q_ids.push_back(cand);
        m_prio  = 1 - m_prio;
        m_lock  = -1;
        pend[cand] = 0;
      end else if (cand >= 0 && pend[cand]) begin
        m_lock = cand;
      end else begin
        m_lock = -1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
